// File: rtl/ctrl_pipe.sv
// Control carrier and hazard unit for the 5-stage core: carries decoder
// controls ID->EX->MEM->WB, detects load-use and taken-branch hazards.
module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_memRead,
    input  logic             id_memtoReg,
    input  logic             id_memWrite,
    input  logic             id_ALUSrc,
    input  logic             id_regWrite,
    input  logic [2:0]       id_ALUOp,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_memRead,
    output logic             ex_memtoReg,
    output logic             ex_memWrite,
    output logic             ex_ALUSrc,
    output logic             ex_regWrite,
    output logic [2:0]       ex_ALUOp,
    output logic [4:0]       ex_rd,
    output logic             mem_valid,
    output logic             mem_memRead,
    output logic             mem_memWrite,
    output logic             mem_memtoReg,
    output logic             mem_regWrite,
    output logic [4:0]       mem_rd,
    output logic             wb_valid,
    output logic             wb_memtoReg,
    output logic             wb_regWrite,
    output logic [4:0]       wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic       load_use;
    logic       taken;
    logic       bubble;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       wb_hit_a;
    logic       wb_hit_b;

    // x0 is never a producer, so a zero ex_rd cannot raise a hazard.
    assign load_use = id_valid & ex_valid & ex_memRead
                    & (ex_rd != 5'd0)
                    & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign taken  = ex_valid & ex_branch & ex_branch_taken;
    assign flush  = taken;
    assign stall  = load_use & ~taken;
    assign bubble = taken | load_use | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memtoReg <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_ALUOp    <= 3'd0;
            ex_rd       <= 5'd0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memtoReg <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_ALUOp    <= 3'd0;
            ex_rd       <= 5'd0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
        end else begin
            ex_valid    <= 1'b1;
            ex_branch   <= id_branch;
            ex_memRead  <= id_memRead;
            ex_memtoReg <= id_memtoReg;
            ex_memWrite <= id_memWrite;
            ex_ALUSrc   <= id_ALUSrc;
            ex_regWrite <= id_regWrite;
            ex_ALUOp    <= id_ALUOp;
            ex_rd       <= id_rd;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_memRead  <= 1'b0;
            mem_memWrite <= 1'b0;
            mem_memtoReg <= 1'b0;
            mem_regWrite <= 1'b0;
            mem_rd       <= 5'd0;
        end else begin
            mem_valid    <= ex_valid;
            mem_memRead  <= ex_memRead;
            mem_memWrite <= ex_memWrite;
            mem_memtoReg <= ex_memtoReg;
            mem_regWrite <= ex_regWrite;
            mem_rd       <= ex_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_memtoReg <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_rd       <= 5'd0;
        end else begin
            wb_valid    <= mem_valid;
            wb_memtoReg <= mem_memtoReg;
            wb_regWrite <= mem_regWrite;
            wb_rd       <= mem_rd;
        end
    end

    assign mem_hit_a = mem_valid & mem_regWrite & (mem_rd != 5'd0)
                     & (mem_rd == ex_rs1);
    assign mem_hit_b = mem_valid & mem_regWrite & (mem_rd != 5'd0)
                     & (mem_rd == ex_rs2);
    assign wb_hit_a  = wb_valid & wb_regWrite & (wb_rd != 5'd0)
                     & (wb_rd == ex_rs1);
    assign wb_hit_b  = wb_valid & wb_regWrite & (wb_rd != 5'd0)
                     & (wb_rd == ex_rs2);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_hit_a)
            fwd_a = FWD_MEM;
        else if (wb_hit_a)
            fwd_a = FWD_WB;
        if (mem_hit_b)
            fwd_b = FWD_MEM;
        else if (wb_hit_b)
            fwd_b = FWD_WB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and random checks of ctrl_pipe against an instruction-record
// pipeline model.
module tb_ctrl_pipe;

    typedef struct {
        logic       v, br, mr, mt, mw, as, rw;
        logic [2:0] op;
        logic [4:0] rd, rs1, rs2;
    } ins_t;

    logic       clk;
    logic       rst;
    logic       id_valid, id_branch, id_memRead, id_memtoReg;
    logic       id_memWrite, id_ALUSrc, id_regWrite;
    logic [2:0] id_ALUOp;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       ex_branch_taken;
    logic       stall, flush;
    logic       ex_valid, ex_branch, ex_memRead, ex_memtoReg;
    logic       ex_memWrite, ex_ALUSrc, ex_regWrite;
    logic [2:0] ex_ALUOp;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_memRead, mem_memWrite;
    logic       mem_memtoReg, mem_regWrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_memtoReg, wb_regWrite;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    ins_t cur, nop, m_ex, m_mem, m_wb;
    int   sc, fc;
    bit   es, ef;

    ctrl_pipe #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_branch(id_branch),
        .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
        .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc),
        .id_regWrite(id_regWrite), .id_ALUOp(id_ALUOp),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg),
        .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_regWrite(ex_regWrite), .ex_ALUOp(ex_ALUOp),
        .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_memtoReg(mem_memtoReg),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_memtoReg(wb_memtoReg),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic drive(input ins_t i);
        cur         = i;
        id_valid    = i.v;
        id_branch   = i.br;
        id_memRead  = i.mr;
        id_memtoReg = i.mt;
        id_memWrite = i.mw;
        id_ALUSrc   = i.as;
        id_regWrite = i.rw;
        id_ALUOp    = i.op;
        id_rd       = i.rd;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
    endtask

    function automatic ins_t mk(logic br, logic mr, logic mt, logic mw,
                                logic rw, logic [2:0] op, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2);
        ins_t i;
        i = '{default: '0};
        i.v = 1'b1; i.br = br; i.mr = mr; i.mt = mt; i.mw = mw;
        i.rw = rw; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    task automatic model_clear();
        m_ex = nop; m_mem = nop; m_wb = nop;
        sc = 0; fc = 0;
    endtask

    function automatic int sat(int n);
        return (n > 15) ? 15 : n;
    endfunction

    // Youngest in-flight writer of a nonzero register supplies the operand.
    function automatic logic [1:0] src_of(logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (m_mem.v && m_mem.rw && m_mem.rd == rs) return 2'd2;
        if (m_wb.v && m_wb.rw && m_wb.rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_all();
        if (rst) model_clear();
        ef = m_ex.v && m_ex.br && ex_branch_taken;
        es = cur.v && m_ex.v && m_ex.mr && m_ex.rd != 0
             && (m_ex.rd == cur.rs1 || m_ex.rd == cur.rs2) && !ef;
        chk("stall", stall, es);
        chk("flush", flush, ef);
        chk("ex_valid", ex_valid, m_ex.v);
        chk("ex_branch", ex_branch, m_ex.br);
        chk("ex_memRead", ex_memRead, m_ex.mr);
        chk("ex_memtoReg", ex_memtoReg, m_ex.mt);
        chk("ex_memWrite", ex_memWrite, m_ex.mw);
        chk("ex_ALUSrc", ex_ALUSrc, m_ex.as);
        chk("ex_regWrite", ex_regWrite, m_ex.rw);
        chk("ex_ALUOp", ex_ALUOp, m_ex.op);
        chk("ex_rd", ex_rd, m_ex.rd);
        chk("mem_valid", mem_valid, m_mem.v);
        chk("mem_memRead", mem_memRead, m_mem.mr);
        chk("mem_memWrite", mem_memWrite, m_mem.mw);
        chk("mem_memtoReg", mem_memtoReg, m_mem.mt);
        chk("mem_regWrite", mem_regWrite, m_mem.rw);
        chk("mem_rd", mem_rd, m_mem.rd);
        chk("wb_valid", wb_valid, m_wb.v);
        chk("wb_memtoReg", wb_memtoReg, m_wb.mt);
        chk("wb_regWrite", wb_regWrite, m_wb.rw);
        chk("wb_rd", wb_rd, m_wb.rd);
        chk("fwd_a", fwd_a, src_of(m_ex.rs1));
        chk("fwd_b", fwd_b, src_of(m_ex.rs2));
        chk("stall_cnt", stall_cnt, sat(sc));
        chk("flush_cnt", flush_cnt, sat(fc));
    endtask

    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (ef || es || !cur.v) m_ex = nop;
            else m_ex = cur;
            if (es) sc++;
            if (ef) fc++;
        end
        #1;
    endtask

    task automatic drain();
        drive(nop);
        repeat (3) tick();
    endtask

    initial begin
        ins_t r;
        nop = '{default: '0};
        ex_branch_taken = 1'b0;
        model_clear();

        // reset with a live writer in ID
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd1, 5'd0, 5'd0));
        tick();
        chk("rst_ex_regWrite", ex_regWrite, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ex_regWrite", ex_regWrite, 1'b1);

        // load pass-through
        drain();
        drive(mk(0, 1, 1, 0, 1, 3'b010, 5'd5, 5'd1, 5'd2));
        tick();
        chk("pt_ex_memRead", ex_memRead, 1'b1);
        chk("pt_ex_ALUOp", ex_ALUOp, 3'b010);
        drive(nop);
        tick();
        chk("pt_mem_memRead", mem_memRead, 1'b1);
        tick();
        chk("pt_wb_memtoReg", wb_memtoReg, 1'b1);
        chk("pt_wb_rd", wb_rd, 5'd5);

        // load-use
        drain();
        drive(mk(0, 1, 1, 0, 1, 3'b010, 5'd5, 5'd0, 5'd0));
        tick();
        drive(mk(0, 0, 0, 0, 1, 3'b000, 5'd6, 5'd5, 5'd7));
        #3 chk("lu_stall", stall, 1'b1);
        tick();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_stall_cnt", stall_cnt, 4'd1);
        #3 chk("lu_stall_drop", stall, 1'b0);
        tick();
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_ex_rd", ex_rd, 5'd6);

        // forwarding priority and x0
        drain();
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd3, 5'd1, 5'd2));
        tick();
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd3, 5'd1, 5'd2));
        tick();
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd4, 5'd1, 5'd3));
        tick();
        chk("fwd_mem_prio", fwd_b, 2'b10);
        drain();
        drive(mk(0, 1, 1, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0));
        tick();
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0));
        #3 chk("x0_no_stall", stall, 1'b0);
        tick();
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd8, 5'd0, 5'd0));
        tick();
        chk("x0_fwd_b", fwd_b, 2'b00);
        chk("x0_fwd_a", fwd_a, 2'b00);

        // taken branch beats a coincident load-use
        drain();
        drive(mk(1, 1, 0, 0, 0, 3'b001, 5'd5, 5'd1, 5'd2));
        tick();
        ex_branch_taken = 1'b1;
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd6, 5'd5, 5'd0));
        #3 chk("br_flush", flush, 1'b1);
        chk("br_stall_off", stall, 1'b0);
        tick();
        chk("br_bubble", ex_valid, 1'b0);
        chk("br_flush_cnt", flush_cnt, 4'd1);
        chk("br_stall_cnt", stall_cnt, 4'd1);
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd7, 5'd1, 5'd1));
        tick();
        #3 chk("nobr_flush", flush, 1'b0);
        ex_branch_taken = 1'b0;

        // counter saturation: self-dependent load stalls every other cycle
        drain();
        drive(mk(0, 1, 1, 0, 1, 3'b010, 5'd5, 5'd5, 5'd0));
        repeat (40) tick();
        chk("sat_stall_cnt", stall_cnt, 4'd15);

        // asynchronous reset mid-flight
        drive(mk(0, 0, 0, 0, 1, 3'd0, 5'd9, 5'd1, 5'd2));
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", ex_valid, 1'b0);
        chk("async_rst_stall_cnt", stall_cnt, 4'd0);
        tick();
        rst = 1'b0;

        // random traffic with small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            r = '{default: '0};
            r.v   = ($urandom_range(0, 3) != 0);
            r.br  = ($urandom_range(0, 5) == 0);
            r.mr  = ($urandom_range(0, 2) == 0);
            r.mt  = r.mr;
            r.mw  = !r.mr && ($urandom_range(0, 4) == 0);
            r.as  = $urandom_range(0, 1);
            r.rw  = $urandom_range(0, 1);
            r.op  = 3'($urandom_range(0, 7));
            r.rd  = 5'($urandom_range(0, 3));
            r.rs1 = 5'($urandom_range(0, 3));
            r.rs2 = 5'($urandom_range(0, 3));
            drive(r);
            ex_branch_taken = $urandom_range(0, 1);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
